muldiv_seq: RTL and testbench



---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_step.sv | 55 +++++
 rtl/muldiv_seq.sv | 155 +++++++++++++++
 tb/tb_muldiv_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the multi-cycle multiply/divide sequencer:
//   - MIPS funct codes handled beside the single-cycle ALU
//   - sequencer state encoding
//   - default operand width
//   - helper to classify mul/div funct codes
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // The four mul/div codes share the prefix 0110; bit 1 selects divide
    // and bit 0 selects the unsigned variant.
    function automatic logic is_muldiv(input logic [5:0] funct);
        return funct[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
// Combinational single iteration of the shift-add multiply or the
// restoring divide. Both operations share one 2*WIDTH accumulator:
//   multiply: {partial product upper word, remaining multiplier bits}
//   divide:   {partial remainder, dividend bits / quotient bits so far}
// Ports:
//   is_div    in   1        1 = divide iteration, 0 = multiply iteration
//   acc       in   2*WIDTH  current accumulator
//   operand   in   WIDTH    multiplicand (multiply) or divisor (divide)
//   acc_next  out  2*WIDTH  accumulator after this iteration (quotient
//                           slot left at 0 for divide)
//   qbit      out  1        quotient bit produced by a divide iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic                 qbit
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH-1:0] new_rem;

    // Multiply: LSB-first, add the multiplicand into the upper word when the
    // current multiplier bit is set, then shift the whole accumulator right
    // taking the carry into the top bit.
    // Divide: shift the next dividend bit into the partial remainder, which
    // momentarily needs WIDTH+1 bits. The subtraction is done on WIDTH bits;
    // whenever it is taken the true difference is below the divisor, so the
    // wrapped WIDTH-bit result is exact.
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        shifted  = acc[2*WIDTH-1:WIDTH-1];
        new_rem  = shifted[WIDTH-1:0];
        qbit     = 1'b0;
        acc_next = acc;
        if (is_div) begin
            qbit = shifted[WIDTH] | (shifted[WIDTH-1:0] >= operand);
            if (qbit) begin
                new_rem = shifted[WIDTH-1:0] - operand;
            end
            acc_next = {new_rem, acc[WIDTH-2:0], 1'b0};
        end else if (acc[0]) begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Multi-cycle sequencer for MULT/MULTU/DIV/DIVU plus the HI/LO pair.
// Runs WIDTH iterations on operand magnitudes, then applies sign
// correction and writes hi/lo. Also services MTHI/MTLO directly.
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-high reset
//   start    in   1      EX stage holds a muldiv-class instruction
//   alufunc  in   6      MIPS funct field
//   RA       in   WIDTH  rs operand
//   RB       in   WIDTH  rt operand
//   busy     out  1      operation in flight, pipeline must stall
//   done     out  1      one-cycle pulse when hi/lo have been updated
//   hi       out  WIDTH  HI register
//   lo       out  WIDTH  LO register
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        alufunc,
    input  logic [WIDTH-1:0]  RA,
    input  logic [WIDTH-1:0]  RB,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic               op_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;

    logic               op_signed;
    logic               ra_neg;
    logic               rb_neg;
    logic [WIDTH-1:0]   ra_mag;
    logic [WIDTH-1:0]   rb_mag;

    logic [2*WIDTH-1:0] step_acc;
    logic               step_q;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes for the signed variants. Negating 0x80000000 gives
    // 0x80000000 again, which is exactly the right unsigned magnitude.
    always_comb begin
        op_signed = ~alufunc[0];
        ra_neg    = op_signed & RA[WIDTH-1];
        rb_neg    = op_signed & RB[WIDTH-1];
        ra_mag    = ra_neg ? -RA : RA;
        rb_mag    = rb_neg ? -RB : RB;
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div   (op_div),
        .acc      (acc),
        .operand  (operand),
        .acc_next (step_acc),
        .qbit     (step_q)
    );

    // Sign correction applied on the way out of FIX. A zero divisor skips
    // quotient correction so lo reads all ones; the remainder path already
    // reproduces the original dividend because its magnitude passes through
    // untouched and then regains the dividend's sign.
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        if (div_zero) begin
            quot_fix = '1;
        end
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Main sequencer. start is only looked at in IDLE, so a request that
    // arrives while busy is dropped and the controller re-presents it. The
    // cycle done is high is back in IDLE and can accept the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            operand  <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (alufunc == MTHI) begin
                            hi <= RA;
                        end else if (alufunc == MTLO) begin
                            lo <= RA;
                        end else if (is_muldiv(alufunc)) begin
                            op_div   <= alufunc[1];
                            acc      <= {{WIDTH{1'b0}}, ra_mag};
                            operand  <= rb_mag;
                            neg_res  <= ra_neg ^ rb_neg;
                            neg_rem  <= ra_neg;
                            div_zero <= alufunc[1] && (RB == '0);
                            cnt      <= '0;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (op_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq
// Self-checking bench for muldiv_seq. Expected hi/lo pairs are queued when
// an operation is started and compared when the DUT pulses done.
module tb_muldiv_seq;

    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  alufunc;
    logic [31:0] RA;
    logic [31:0] RB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          e0;
        string       tag;
    } exp_t;

    exp_t expq[$];
    int   checks;
    int   errors;
    int   cyc;

    muldiv_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .alufunc (alufunc),
        .RA      (RA),
        .RB      (RB),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    // 10 ns clock and a rising-edge counter used to measure latency.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model for the four mul/div codes.
    task automatic model(input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] h,
                         output logic [31:0] l);
        logic [63:0] p;
        longint      sp;
        int          sa;
        int          sb;
        int          q;
        int          r;
        h = '0;
        l = '0;
        sa = a;
        sb = b;
        case (f)
            F_MULTU: begin
                p = {32'h0, a} * {32'h0, b};
                h = p[63:32];
                l = p[31:0];
            end
            F_MULT: begin
                sp = longint'(sa) * longint'(sb);
                p = sp;
                h = p[63:32];
                l = p[31:0];
            end
            F_DIVU: begin
                if (b == 32'h0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            default: begin
                if (b == 32'h0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    h = 32'h0;
                    l = 32'h8000_0000;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    l = q;
                    h = r;
                end
            end
        endcase
    endtask

    // Present one start cycle; operands are scrambled right after E0 so that
    // any late sampling of RA/RB would corrupt the result.
    task automatic driveStart(input logic [5:0] f, input logic [31:0] a,
                              input logic [31:0] b);
        start   = 1'b1;
        alufunc = f;
        RA      = a;
        RB      = b;
        @(negedge clk);
        start   = 1'b0;
        alufunc = 6'b100000;
        RA      = $urandom;
        RB      = $urandom;
    endtask

    task automatic applyStimulus(input string tag, input logic [5:0] f,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        e.exp_hi = eh;
        e.exp_lo = el;
        e.e0     = cyc + 1;
        e.tag    = tag;
        expq.push_back(e);
        driveStart(f, a, b);
    endtask

    // Called on the first falling edge after E0. Busy must already be high
    // and stay high until done; the wait is bounded.
    task automatic waitDone(input string tag);
        int n;
        logic gap;
        n   = 0;
        gap = 1'b0;
        checkOutput({tag, "_busy_rise"}, {31'h0, busy}, 32'h1);
        while (!done && n < 40) begin
            if (!busy) gap = 1'b1;
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_done_seen"}, {31'h0, done}, 32'h1);
        checkOutput({tag, "_busy_gap"}, {31'h0, gap}, 32'h0);
    endtask

    // Scoreboard side: every done pulse pops one expectation and checks the
    // result, the E0-to-done latency of 33 edges, and that busy has dropped.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_done", {31'h0, done}, 32'h0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                checkOutput({e.tag, "_hi"}, hi, e.exp_hi);
                checkOutput({e.tag, "_lo"}, lo, e.exp_lo);
                checkOutput({e.tag, "_latency"}, 32'(cyc - e.e0), 32'd33);
                checkOutput({e.tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
            end
        end
    end

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  fsel [4];
        logic        done_seen;
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        alufunc = 6'h0;
        RA      = 32'h0;
        RB      = 32'h0;
        fsel[0] = F_MULT;
        fsel[1] = F_MULTU;
        fsel[2] = F_DIV;
        fsel[3] = F_DIVU;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_done", {31'h0, done}, 32'h0);
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed mul/div cases");
        applyStimulus("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      32'hFFFF_FFFE, 32'h0000_0001);
        waitDone("multu_max");
        applyStimulus("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'd7,
                      32'hFFFF_FFFF, 32'hFFFF_FFEB);
        waitDone("mult_neg");
        applyStimulus("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2,
                      32'hFFFF_FFFF, 32'hFFFF_FFFD);
        waitDone("div_neg");
        applyStimulus("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                      32'h0000_0000, 32'h8000_0000);
        waitDone("div_ovf");
        applyStimulus("divu_zero", F_DIVU, 32'd100, 32'd0,
                      32'h0000_0064, 32'hFFFF_FFFF);
        waitDone("divu_zero");
        applyStimulus("div_zero_neg", F_DIV, 32'hFFFF_FF00, 32'd0,
                      32'hFFFF_FF00, 32'hFFFF_FFFF);
        waitDone("div_zero_neg");

        $display("[TB] MTHI/MTLO");
        @(negedge clk);
        start   = 1'b1;
        alufunc = F_MTHI;
        RA      = 32'h1234_5678;
        @(negedge clk);
        checkOutput("mthi_hi", hi, 32'h1234_5678);
        checkOutput("mthi_busy", {31'h0, busy}, 32'h0);
        alufunc = F_MTLO;
        RA      = 32'hCAFE_BABE;
        @(negedge clk);
        start   = 1'b0;
        checkOutput("mtlo_lo", lo, 32'hCAFE_BABE);
        checkOutput("mtlo_hi_kept", hi, 32'h1234_5678);
        checkOutput("mtlo_busy", {31'h0, busy}, 32'h0);
        checkOutput("mtlo_done", {31'h0, done}, 32'h0);

        $display("[TB] start while busy is ignored");
        applyStimulus("multu_5x6", F_MULTU, 32'd5, 32'd6, 32'h0, 32'd30);
        repeat (4) @(negedge clk);
        start   = 1'b1;
        alufunc = F_DIVU;
        RA      = 32'd100;
        RB      = 32'd7;
        @(negedge clk);
        start   = 1'b0;
        waitDone("multu_5x6");

        $display("[TB] back-to-back random operations");
        for (int i = 0; i < 8; i++) begin
            f = fsel[i % 4];
            a = $urandom;
            b = (i == 5) ? 32'h8000_0000 : 32'($urandom);
            if (i == 6) a = 32'h8000_0000;
            model(f, a, b, eh, el);
            applyStimulus($sformatf("rand%0d", i), f, a, b, eh, el);
            waitDone($sformatf("rand%0d", i));
        end

        $display("[TB] reset during an operation");
        @(negedge clk);
        driveStart(F_MULTU, 32'd9, 32'd9);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_mid_hi", hi, 32'h0);
        checkOutput("rst_mid_lo", lo, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        checkOutput("rst_no_done", {31'h0, done_seen}, 32'h0);
        applyStimulus("multu_9x9", F_MULTU, 32'd9, 32'd9, 32'h0, 32'd81);
        waitDone("multu_9x9");

        @(negedge clk);
        checkOutput("queue_drained", 32'(expq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
